// File: rtl/seq_monitor_if.sv
// Sample stream into, and classification/status out of, the seq_monitor block.
// The master drives samples and observes status; the slave is the monitor.
interface seq_monitor_if #(
  parameter int WIDTH = 4,
  parameter int RUN_W = 8
);
  logic             valid;
  logic [WIDTH-1:0] value;
  logic             cls_valid;
  logic [1:0]       cls;
  logic             locked;
  logic             dir_up;
  logic [RUN_W-1:0] run_len;
  logic [RUN_W-1:0] jump_cnt;
  logic             lost;

  modport master (
    output valid, value,
    input  cls_valid, cls, locked, dir_up, run_len, jump_cnt, lost
  );

  modport slave (
    input  valid, value,
    output cls_valid, cls, locked, dir_up, run_len, jump_cnt, lost
  );
endinterface

// File: rtl/seq_monitor.sv
// Receive-side checker for an up/down counter stream: classifies each sample
// transition, locks onto a counting direction and tracks run/jump statistics.
module seq_monitor #(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 3,
  parameter int RUN_W  = 8
) (
  input logic          clk,
  input logic          rst,
  seq_monitor_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ACQ, LOCKED} state_t;
  typedef enum logic [1:0] {CLS_HOLD = 2'd0, CLS_UP = 2'd1, CLS_DOWN = 2'd2, CLS_JUMP = 2'd3} cls_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [7:0]       acq_cnt;
  cls_t             cls_q;
  logic             cls_valid_q;
  logic             locked_q;
  logic             dir_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] jump_q;
  logic             lost_q;

  logic [WIDTH-1:0] diff;
  cls_t             step_cls;
  logic             step_up;
  logic             continue_run;
  logic [7:0]       acq_next;
  logic [RUN_W-1:0] run_inc;
  logic [RUN_W-1:0] run_step;
  logic [RUN_W-1:0] jump_inc;

  // Modular difference makes the 15->0 and 0->15 wraps fall out as +1 / -1.
  assign diff = bus.value - prev;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    step_cls = CLS_JUMP;
    if (diff == '0)
      step_cls = CLS_HOLD;
    else if (diff == WIDTH'(1))
      step_cls = CLS_UP;
    else if (diff == '1)
      step_cls = CLS_DOWN;
  end

  assign step_up  = (step_cls == CLS_UP);
  assign run_inc  = (run_q == '1) ? run_q : run_q + RUN_W'(1);
  assign jump_inc = (jump_q == '1) ? jump_q : jump_q + RUN_W'(1);

  // The first step after EMPTY or a jump adopts its own direction.
  assign continue_run = ((state == ACQ) && (acq_cnt == 8'd0)) || (step_up == dir_q);
  assign acq_next     = continue_run ? acq_cnt + 8'd1 : 8'd1;
  assign run_step     = continue_run ? run_inc : RUN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      prev        <= '0;
      acq_cnt     <= '0;
      cls_q       <= CLS_HOLD;
      cls_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      dir_q       <= 1'b0;
      run_q       <= '0;
      jump_q      <= '0;
      lost_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; these pulse defaults are overridden by later assignments in this block.
      cls_valid_q <= 1'b0;
      lost_q      <= 1'b0;
      if (bus.valid) begin
        prev <= bus.value;
        case (state)
          EMPTY: begin
            state   <= ACQ;
            acq_cnt <= '0;
          end
          ACQ: begin
            cls_valid_q <= 1'b1;
            cls_q       <= step_cls;
            if (step_cls == CLS_JUMP) begin
              acq_cnt <= '0;
              run_q   <= '0;
              jump_q  <= jump_inc;
            end else if (step_cls != CLS_HOLD) begin
              dir_q   <= step_up;
              acq_cnt <= acq_next;
              run_q   <= run_step;
              if (acq_next >= 8'(LOCK_N)) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
          LOCKED: begin
            cls_valid_q <= 1'b1;
            cls_q       <= step_cls;
            if (step_cls == CLS_JUMP) begin
              state    <= ACQ;
              acq_cnt  <= '0;
              locked_q <= 1'b0;
              lost_q   <= 1'b1;
              run_q    <= '0;
              jump_q   <= jump_inc;
            end else if (step_cls != CLS_HOLD) begin
              dir_q <= step_up;
              run_q <= run_step;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign bus.cls_valid = cls_valid_q;
  assign bus.cls       = cls_q;
  assign bus.locked    = locked_q;
  assign bus.dir_up    = dir_q;
  assign bus.run_len   = run_q;
  assign bus.jump_cnt  = jump_q;
  assign bus.lost      = lost_q;

endmodule

// File: doc/seq_monitor.md
Name: seq_monitor

Overview:
- Receive-side checker for the 4-bit loadable up/down counter stream produced by the counter FSM.
- Samples the counter value on each qualified cycle and classifies every transition as hold, up, down or jump (load).
- Locks onto a counting direction and reports run length, direction and jump statistics to the rest of the design.

Parameters:
- WIDTH, 4, width of the monitored counter value; must be >= 2.
- LOCK_N, 3, consecutive same-direction steps required to declare lock; range 1..255.
- RUN_W, 8, width of the run-length and jump counters.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- valid  input  1  value is a new sample this cycle.
- value  input  WIDTH  observed counter value.
- cls_valid  output  1  one-cycle pulse; cls and the status outputs were updated by the sample taken on the previous edge.
- cls  output  2  transition class: 0 hold, 1 up, 2 down, 3 jump.
- locked  output  1  direction lock established.
- dir_up  output  1  current locked or acquiring direction; 1 means up.
- run_len  output  RUN_W  consecutive same-direction steps; saturating.
- jump_cnt  output  RUN_W  total jumps since reset; saturating.
- lost  output  1  one-cycle pulse when a jump breaks lock.

Behaviour:
- Reset, synchronous and active-high:
  - All outputs and internal state cleared next edge: cls=0, cls_valid=0, locked=0, dir_up=0, run_len=0, jump_cnt=0, lost=0.
  - FSM returns to EMPTY.
  - Reset mid-operation discards prev and all counts.
- valid=0: no state change. cls_valid and lost are 0 the following cycle; other outputs hold.
- Classification, modulo 2^WIDTH, for a sample compared against stored prev:
  - value==prev gives hold.
  - value==prev+1 gives up; the wrap 15->0 counts as up.
  - value==prev-1 gives down; the wrap 0->15 counts as down.
  - Any other value gives jump.
  - prev <= value on every valid sample.
- Latency: a sample at edge N produces cls/cls_valid/status visible after edge N+1, i.e. 1 cycle registered.
- FSM states: EMPTY, ACQ, LOCKED.
- EMPTY:
  - On the first valid sample: store prev, go to ACQ, acq_cnt=0.
  - cls_valid stays 0, since there is nothing to compare against.
- ACQ:
  - hold: no count change.
  - Step in the same direction as dir_up, or the first step when acq_cnt=0: acq_cnt++, run_len++, dir_up set to the step direction.
  - Step in the opposite direction: dir_up flips, acq_cnt=1, run_len=1.
  - jump: acq_cnt=0, run_len=0, jump_cnt++. lost is not asserted.
  - When acq_cnt reaches LOCK_N: go to LOCKED, locked=1, on the same edge as the step that completes the count.
- LOCKED:
  - hold: no change.
  - Same-direction step: run_len++, saturating at 2^RUN_W-1.
  - Reversal: dir_up flips, run_len=1. Lock is kept, because a direction change is legal counter behaviour.
  - jump: locked=0, lost=1 for one cycle, jump_cnt++, run_len=0, go to ACQ with acq_cnt=0.
- Saturation: run_len and jump_cnt never wrap.
- Simultaneous rst and valid: rst wins and the sample is discarded.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, valid=0 -> all outputs 0, cls_valid never pulses.
- Lock up with wrap: samples 13,14,15,0 with LOCK_N=3 -> cls=1,1,1 (the 15->0 step is up); locked=1 and dir_up=1 after the 4th sample; run_len=3.
- Reversal keeps lock: from the locked-up state, samples 0,15,14 -> cls=0 (hold), then 2,2; dir_up=0; locked stays 1; run_len=2.
- Jump breaks lock: while locked at 5, sample 9 -> cls=3, lost pulses once, locked=0, jump_cnt=1. Then 10,11,12 -> relock with dir_up=1.
- Gaps and reset mid-run: samples 3,(valid=0 x3),4 -> classified up, with the gap ignored. Assert rst during ACQ -> EMPTY; the next sample yields no cls_valid.
- Saturation: RUN_W=2, 6 consecutive up steps -> run_len stops at 3. 5 jumps -> jump_cnt=3.
